// File: rtl/tow_match_core.sv
// ============================================================================
// Module   : tow_match_core
// Brief    : Parametrised tug-of-war match engine (rope position, lockout,
//            round and match scoring). Optional macro BLINK_EN blinks the
//            winner's edge LED while the match is over.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tow_match_core #(
   parameter int NUM_LEDS      = 7,
   parameter int WINS_TO_MATCH = 3,
   parameter int WIN_W         = 4,
   parameter int LOCKOUT_CYC   = 64,
   parameter int HOLD_CYC      = 256,
   parameter int BLINK_CYC     = 128
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push_l,
   input  logic                        push_r,
   input  logic                        clear,
   output logic [NUM_LEDS-1:0]         leds_out,
   output logic [$clog2(NUM_LEDS)-1:0] pos,
   output logic [WIN_W-1:0]            score_l,
   output logic [WIN_W-1:0]            score_r,
   output logic                        tie,
   output logic                        round_win,
   output logic                        match_done,
   output logic [1:0]                  winner
);

   localparam int POS_W   = $clog2(NUM_LEDS);
   localparam int CNT_MAX = (LOCKOUT_CYC > HOLD_CYC) ?
                            ((LOCKOUT_CYC > BLINK_CYC) ? LOCKOUT_CYC : BLINK_CYC) :
                            ((HOLD_CYC > BLINK_CYC) ? HOLD_CYC : BLINK_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [POS_W-1:0]    c_centre     = POS_W'((NUM_LEDS - 1) / 2);
   localparam logic [POS_W-1:0]    c_right_edge = POS_W'(NUM_LEDS - 1);
   localparam logic [NUM_LEDS-1:0] c_centre_led = NUM_LEDS'(1) << ((NUM_LEDS - 1) / 2);
   localparam logic [WIN_W-1:0]    c_wins       = WIN_W'(WINS_TO_MATCH);
   localparam logic [CNT_W-1:0]    c_lock_load  = CNT_W'(LOCKOUT_CYC);
   localparam logic [CNT_W-1:0]    c_hold_load  = CNT_W'(HOLD_CYC);
`ifdef BLINK_EN
   localparam logic [CNT_W-1:0]    c_match_load = CNT_W'(BLINK_CYC - 1);
`else
   localparam logic [CNT_W-1:0]    c_match_load = '0;
`endif

   localparam logic [1:0] c_st_play  = 2'd0;
   localparam logic [1:0] c_st_lock  = 2'd1;
   localparam logic [1:0] c_st_round = 2'd2;
   localparam logic [1:0] c_st_match = 2'd3;

   logic [1:0]          r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [POS_W-1:0]    r_pos, w_pos_nxt;
   logic [WIN_W-1:0]    r_score_l, w_score_l_nxt;
   logic [WIN_W-1:0]    r_score_r, w_score_r_nxt;
   logic [NUM_LEDS-1:0] r_leds, w_leds_nxt;
   logic [1:0]          r_winner, w_winner_nxt;
   logic                r_tie, w_tie_nxt;
   logic                r_round_win, w_round_win_nxt;
   logic                r_blink_on, w_blink_on_nxt;

   logic             w_cnt_last;
   logic             w_live;
   logic             w_move;
   logic [POS_W-1:0] w_step_pos;
   logic             w_left_pt;
   logic             w_right_pt;
   logic             w_edge_hit;
   logic             w_match_win;

   // The final lockout cycle already accepts pushes, so the first accepted
   // push lands exactly LOCKOUT_CYC cycles after the move.
   assign w_cnt_last  = (r_cnt <= CNT_W'(1));
   assign w_live      = (r_state == c_st_play) || ((r_state == c_st_lock) && w_cnt_last);
   assign w_move      = w_live && (push_l ^ push_r);
   assign w_step_pos  = push_l ? (r_pos - POS_W'(1)) : (r_pos + POS_W'(1));
   assign w_left_pt   = w_move && push_l && (w_step_pos == '0);
   assign w_right_pt  = w_move && push_r && (w_step_pos == c_right_edge);
   assign w_edge_hit  = w_left_pt || w_right_pt;
   assign w_match_win = (w_left_pt  && ((r_score_l + WIN_W'(1)) == c_wins)) ||
                        (w_right_pt && ((r_score_r + WIN_W'(1)) == c_wins));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state     <= c_st_play;
         r_cnt       <= '0;
         r_pos       <= c_centre;
         r_score_l   <= '0;
         r_score_r   <= '0;
         r_leds      <= c_centre_led;
         r_winner    <= 2'b00;
         r_tie       <= 1'b0;
         r_round_win <= 1'b0;
         r_blink_on  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pos       <= w_pos_nxt;
         r_score_l   <= w_score_l_nxt;
         r_score_r   <= w_score_r_nxt;
         r_leds      <= w_leds_nxt;
         r_winner    <= w_winner_nxt;
         r_tie       <= w_tie_nxt;
         r_round_win <= w_round_win_nxt;
         r_blink_on  <= w_blink_on_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_st_play, c_st_lock: begin
            if (w_move) begin
               if (w_match_win) begin
                  w_state_nxt = c_st_match;
                  w_cnt_nxt   = c_match_load;
               end else if (w_edge_hit) begin
                  w_state_nxt = c_st_round;
                  w_cnt_nxt   = c_hold_load;
               end else begin
                  w_state_nxt = c_st_lock;
                  w_cnt_nxt   = c_lock_load;
               end
            end else if (r_state == c_st_lock) begin
               if (w_cnt_last) begin
                  w_state_nxt = c_st_play;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt - CNT_W'(1);
               end
            end
         end
         c_st_round: begin
            if (w_cnt_last) begin
               w_state_nxt = c_st_play;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
         end
         default: begin
`ifdef BLINK_EN
            // The idle round counter doubles as the blink timer.
            if (r_cnt == '0) w_cnt_nxt = c_match_load;
            else             w_cnt_nxt = r_cnt - CNT_W'(1);
`endif
         end
      endcase
   end

   always_comb begin
      w_pos_nxt       = r_pos;
      w_score_l_nxt   = r_score_l;
      w_score_r_nxt   = r_score_r;
      w_winner_nxt    = r_winner;
      w_tie_nxt       = w_live && push_l && push_r;
      w_round_win_nxt = w_edge_hit;
      w_blink_on_nxt  = r_blink_on;

      if (w_move)
         w_pos_nxt = w_step_pos;
      else if ((r_state == c_st_round) && w_cnt_last)
         w_pos_nxt = c_centre;

      if (w_left_pt  && (r_score_l != c_wins)) w_score_l_nxt = r_score_l + WIN_W'(1);
      if (w_right_pt && (r_score_r != c_wins)) w_score_r_nxt = r_score_r + WIN_W'(1);
      if (w_match_win) w_winner_nxt = w_left_pt ? 2'b01 : 2'b10;

      if ((r_state != c_st_match) && (w_state_nxt == c_st_match))
         w_blink_on_nxt = 1'b1;
      else if ((r_state == c_st_match) && (r_cnt == '0))
         w_blink_on_nxt = ~r_blink_on;

      w_leds_nxt = NUM_LEDS'(1) << w_pos_nxt;
`ifdef BLINK_EN
      if ((w_state_nxt == c_st_match) && !w_blink_on_nxt) w_leds_nxt = '0;
`endif
   end

   assign leds_out   = r_leds;
   assign pos        = r_pos;
   assign score_l    = r_score_l;
   assign score_r    = r_score_r;
   assign tie        = r_tie;
   assign round_win  = r_round_win;
   assign match_done = (r_state == c_st_match);
   assign winner     = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_tow_match_core.sv
// ============================================================================
// Module   : tb_tow_match_core
// Brief    : Directed self-checking bench for tow_match_core (7 LEDs, 2 wins,
//            lockout 4, hold 8, blink half-period 2 when BLINK_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tow_match_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       push_l = 1'b0;
   logic       push_r = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] leds_out;
   logic [2:0] pos;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic       tie;
   logic       round_win;
   logic       match_done;
   logic [1:0] winner;

   int total = 0;
   int bad   = 0;

   tow_match_core #(
      .NUM_LEDS      (7),
      .WINS_TO_MATCH (2),
      .WIN_W         (4),
      .LOCKOUT_CYC   (4),
      .HOLD_CYC      (8),
      .BLINK_CYC     (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .push_l     (push_l),
      .push_r     (push_r),
      .clear      (clear),
      .leds_out   (leds_out),
      .pos        (pos),
      .score_l    (score_l),
      .score_r    (score_r),
      .tie        (tie),
      .round_win  (round_win),
      .match_done (match_done),
      .winner     (winner)
   );

   always #5 clk = ~clk;

   // Inputs change on negedges; each pulse is sampled by exactly one posedge.
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic l, input logic r);
      push_l = l;
      push_r = r;
      @(negedge clk);
      push_l = 1'b0;
      push_r = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      total++; if (pos !== 3'd3) begin bad++; $display("FAIL reset_pos got=%0d exp=3", pos); end
      total++; if (leds_out !== 7'b0001000) begin bad++; $display("FAIL reset_leds got=%b exp=0001000", leds_out); end
      total++; if ({score_l, score_r} !== 8'h00) begin bad++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_l, score_r); end
      total++; if ({tie, round_win, match_done, winner} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {tie, round_win, match_done, winner}); end
   endtask

   task automatic test_lockout;
      pulse(1'b0, 1'b1);
      total++; if (pos !== 3'd4) begin bad++; $display("FAIL move_r_pos got=%0d exp=4", pos); end
      total++; if (leds_out !== 7'b0010000) begin bad++; $display("FAIL move_r_leds got=%b exp=0010000", leds_out); end
      cyc(1);
      pulse(1'b0, 1'b1);
      total++; if (pos !== 3'd4) begin bad++; $display("FAIL lock_ignore2 got=%0d exp=4", pos); end
      cyc(1);
      pulse(1'b0, 1'b1);
      total++; if (pos !== 3'd5) begin bad++; $display("FAIL lock_accept4 got=%0d exp=5", pos); end
      total++; if (leds_out !== 7'b0100000) begin bad++; $display("FAIL lock_accept4_leds got=%b exp=0100000", leds_out); end
      cyc(2);
      pulse(1'b1, 1'b0);
      total++; if (pos !== 3'd5) begin bad++; $display("FAIL lock_ignore3 got=%0d exp=5", pos); end
      cyc(1);
      pulse(1'b1, 1'b0);
      cyc(3);
      pulse(1'b1, 1'b0);
      total++; if (pos !== 3'd3) begin bad++; $display("FAIL back_to_centre got=%0d exp=3", pos); end
      cyc(4);
   endtask

   task automatic test_tie;
      pulse(1'b1, 1'b1);
      total++; if (tie !== 1'b1) begin bad++; $display("FAIL tie_pulse got=%b exp=1", tie); end
      total++; if (pos !== 3'd3) begin bad++; $display("FAIL tie_pos got=%0d exp=3", pos); end
      pulse(1'b1, 1'b0);
      total++; if (tie !== 1'b0) begin bad++; $display("FAIL tie_width got=%b exp=0", tie); end
      total++; if (pos !== 3'd2) begin bad++; $display("FAIL after_tie_pos got=%0d exp=2", pos); end
      cyc(3);
      pulse(1'b0, 1'b1);
      cyc(4);
   endtask

   task automatic test_round;
      pulse(1'b0, 1'b1);
      cyc(3);
      pulse(1'b0, 1'b1);
      cyc(3);
      pulse(1'b0, 1'b1);
      total++; if (pos !== 3'd6) begin bad++; $display("FAIL round_pos got=%0d exp=6", pos); end
      total++; if (round_win !== 1'b1) begin bad++; $display("FAIL round_win got=%b exp=1", round_win); end
      total++; if (score_r !== 4'd1 || score_l !== 4'd0) begin bad++; $display("FAIL round_score got=%0d/%0d exp=0/1", score_l, score_r); end
      total++; if (leds_out !== 7'b1000000) begin bad++; $display("FAIL round_leds got=%b exp=1000000", leds_out); end
      pulse(1'b0, 1'b1);
      total++; if (round_win !== 1'b0 || pos !== 3'd6) begin bad++; $display("FAIL hold_r got=%b/%0d exp=0/6", round_win, pos); end
      pulse(1'b1, 1'b0);
      total++; if (pos !== 3'd6) begin bad++; $display("FAIL hold_l got=%0d exp=6", pos); end
      cyc(5);
      total++; if (pos !== 3'd6) begin bad++; $display("FAIL hold_end7 got=%0d exp=6", pos); end
      cyc(1);
      total++; if (pos !== 3'd3 || leds_out !== 7'b0001000) begin bad++; $display("FAIL recentre got=%0d/%b exp=3/0001000", pos, leds_out); end
   endtask

   task automatic test_match;
      logic [15:0] got;
      pulse(1'b0, 1'b1);
      total++; if (pos !== 3'd4) begin bad++; $display("FAIL play_after_hold got=%0d exp=4", pos); end
      cyc(3);
      pulse(1'b0, 1'b1);
      cyc(3);
      pulse(1'b0, 1'b1);
      total++; if (score_r !== 4'd2) begin bad++; $display("FAIL match_score got=%0d exp=2", score_r); end
      total++; if (match_done !== 1'b1 || winner !== 2'b10) begin bad++; $display("FAIL match_flags got=%b/%b exp=1/10", match_done, winner); end
      total++; if (leds_out !== 7'b1000000 || round_win !== 1'b1) begin bad++; $display("FAIL match_entry got=%b/%b exp=1000000/1", leds_out, round_win); end
`ifdef BLINK_EN
      cyc(1); total++; if (leds_out !== 7'b1000000) begin bad++; $display("FAIL blink1 got=%b exp=1000000", leds_out); end
      cyc(1); total++; if (leds_out !== 7'b0000000) begin bad++; $display("FAIL blink2 got=%b exp=0000000", leds_out); end
      cyc(1); total++; if (leds_out !== 7'b0000000) begin bad++; $display("FAIL blink3 got=%b exp=0000000", leds_out); end
      cyc(1); total++; if (leds_out !== 7'b1000000) begin bad++; $display("FAIL blink4 got=%b exp=1000000", leds_out); end
      total++; if (pos !== 3'd6) begin bad++; $display("FAIL blink_pos got=%0d exp=6", pos); end
`else
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         total++; if (leds_out !== 7'b1000000) begin bad++; $display("FAIL steady%0d got=%b exp=1000000", i, leds_out); end
      end
`endif
      for (int i = 0; i < 100; i++) begin
         push_l = 1'($urandom_range(0, 1));
         push_r = 1'($urandom_range(0, 1));
         @(negedge clk);
         got = {pos, score_l, score_r, match_done, winner, tie, round_win};
         total++;
         if (got !== {3'd6, 4'd0, 4'd2, 1'b1, 2'b10, 1'b0, 1'b0}) begin
            bad++; $display("FAIL match_hold%0d got=%h exp=%h", i, got, {3'd6, 4'd0, 4'd2, 1'b1, 2'b10, 1'b0, 1'b0});
         end
      end
      push_l = 1'b0;
      push_r = 1'b0;
   endtask

   task automatic test_clear;
      clear  = 1'b1;
      push_r = 1'b1;
      @(negedge clk);
      clear  = 1'b0;
      push_r = 1'b0;
      total++; if (pos !== 3'd3 || leds_out !== 7'b0001000) begin bad++; $display("FAIL clear_pos got=%0d/%b exp=3/0001000", pos, leds_out); end
      total++; if ({score_l, score_r} !== 8'h00) begin bad++; $display("FAIL clear_scores got=%0d/%0d exp=0/0", score_l, score_r); end
      total++; if (match_done !== 1'b0 || winner !== 2'b00) begin bad++; $display("FAIL clear_flags got=%b/%b exp=0/00", match_done, winner); end
   endtask

   task automatic test_left_round;
      pulse(1'b1, 1'b0);
      cyc(3);
      pulse(1'b1, 1'b0);
      cyc(3);
      pulse(1'b1, 1'b0);
      total++; if (pos !== 3'd0 || leds_out !== 7'b0000001) begin bad++; $display("FAIL left_edge got=%0d/%b exp=0/0000001", pos, leds_out); end
      total++; if (score_l !== 4'd1 || score_r !== 4'd0) begin bad++; $display("FAIL left_score got=%0d/%0d exp=1/0", score_l, score_r); end
      total++; if (round_win !== 1'b1 || match_done !== 1'b0 || winner !== 2'b00) begin bad++; $display("FAIL left_flags got=%b/%b/%b exp=1/0/00", round_win, match_done, winner); end
   endtask

   task automatic test_rst_clear;
      rst    = 1'b1;
      clear  = 1'b1;
      push_l = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      clear  = 1'b0;
      push_l = 1'b0;
      total++; if (pos !== 3'd3 || score_l !== 4'd0 || round_win !== 1'b0) begin bad++; $display("FAIL rst_clear got=%0d/%0d/%b exp=3/0/0", pos, score_l, round_win); end
      pulse(1'b0, 1'b1);
      total++; if (pos !== 3'd4) begin bad++; $display("FAIL play_after_rst got=%0d exp=4", pos); end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      pulse(1'b1, 1'b0);
      total++; if (pos !== 3'd2) begin bad++; $display("FAIL clear_exits_lock got=%0d exp=2", pos); end
   endtask

   initial begin
      test_reset();
      test_lockout();
      test_tie();
      test_round();
      test_match();
      test_clear();
      test_left_round();
      test_rst_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
